// File: rtl/wb_pipeline_mem_slave.sv
// rtl/wb_pipeline_mem_slave.sv - Wishbone B4 pipelined single-beat memory responder
// Grants the NIC, accepts one request per cycle and answers ACK/ERR after a fixed latency.
`ifndef BUS_DATA_WIDTH
`define BUS_DATA_WIDTH 32
`endif
`ifndef BUS_ADDRESS_WIDTH
`define BUS_ADDRESS_WIDTH 32
`endif
`ifndef BUS_SEL_WIDTH
`define BUS_SEL_WIDTH 4
`endif
`ifndef BUS_TGA_WIDTH
`define BUS_TGA_WIDTH 4
`endif
`ifndef BUS_TGC_WIDTH
`define BUS_TGC_WIDTH 4
`endif

module wb_pipeline_mem_slave #(
  parameter int DATA_WIDTH      = `BUS_DATA_WIDTH,
  parameter int ADDR_WIDTH      = `BUS_ADDRESS_WIDTH,
  parameter int SEL_WIDTH       = `BUS_SEL_WIDTH,
  parameter int TGA_WIDTH       = `BUS_TGA_WIDTH,
  parameter int TGC_WIDTH       = `BUS_TGC_WIDTH,
  parameter int MEM_AW          = 6,
  parameter int LATENCY         = 2,
  parameter int MAX_OUTSTANDING = 2,
  parameter int GNT_DELAY       = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  gnt_wb_o,
  input  logic                  CYC_I,
  input  logic                  STB_I,
  input  logic                  WE_I,
  input  logic [ADDR_WIDTH-1:0] ADR_I,
  input  logic [DATA_WIDTH-1:0] DAT_I,
  input  logic [SEL_WIDTH-1:0]  SEL_I,
  input  logic [TGA_WIDTH-1:0]  TGA_I,
  input  logic [TGC_WIDTH-1:0]  TGC_I,
  input  logic [2:0]            CTI_I,
  output logic [DATA_WIDTH-1:0] DAT_O,
  output logic                  ACK_O,
  output logic                  ERR_O,
  output logic                  RTY_O,
  output logic                  STALL_O
);

  localparam int LSB   = $clog2(SEL_WIDTH);
  localparam int WORDS = 1 << MEM_AW;
  localparam int OW    = $clog2(MAX_OUTSTANDING + 1);
  localparam int GW    = $clog2(GNT_DELAY + 1);
  localparam int LAST  = LATENCY - 1;
  localparam logic [ADDR_WIDTH-1:0] IDX_MASK =
    ADDR_WIDTH'(((64'd1 << MEM_AW) - 64'd1) << LSB);

  logic                  gnt_q, gnt_d;
  logic [GW-1:0]         gnt_cnt_q, gnt_cnt_d;
  logic [OW-1:0]         out_q, out_d;
  logic [LATENCY-1:0]    vld_q, vld_d, err_q, err_d;
  logic [DATA_WIDTH-1:0] dat_q [LATENCY];
  logic [DATA_WIDTH-1:0] dat_d [LATENCY];
  logic                  ack_q, ack_d, err_o_q, err_o_d;
  logic [DATA_WIDTH-1:0] dat_o_q, dat_o_d;
  logic [DATA_WIDTH-1:0] mem_q [WORDS];

  logic [MEM_AW-1:0]     word_idx;
  logic                  req_bad, accept, wr_en, resp_q;
  logic                  unused_tags;

  assign unused_tags = ^{TGA_I, TGC_I, CTI_I};

  // Any address bit outside the word-index field (alignment or range) flags the request.
  assign word_idx = ADR_I[MEM_AW+LSB-1:LSB];
  assign req_bad  = |(ADR_I & ~IDX_MASK);
  assign resp_q   = ack_q | err_o_q;

  assign STALL_O  = CYC_I & (~gnt_q | (out_q == OW'(MAX_OUTSTANDING)));
  assign accept   = CYC_I & STB_I & ~STALL_O;
  assign wr_en    = accept & WE_I & ~req_bad;

  assign gnt_wb_o = gnt_q;
  assign ACK_O    = ack_q;
  assign ERR_O    = err_o_q;
  assign DAT_O    = dat_o_q;
  assign RTY_O    = 1'b0;

  always_comb begin
    gnt_d     = gnt_q;
    gnt_cnt_d = gnt_cnt_q;
    if (!CYC_I) begin
      gnt_d     = 1'b0;
      gnt_cnt_d = '0;
    end else if (!gnt_q) begin
      if (gnt_cnt_q == GW'(GNT_DELAY - 1)) begin
        gnt_d     = 1'b1;
        gnt_cnt_d = '0;
      end else begin
        gnt_cnt_d = gnt_cnt_q + GW'(1);
      end
    end
  end

  // A response leaving the output register this cycle still counts as in flight.
  always_comb begin
    out_d = out_q;
    if (!CYC_I) begin
      out_d = '0;
    end else if (accept && !resp_q) begin
      out_d = out_q + OW'(1);
    end else if (!accept && resp_q) begin
      out_d = out_q - OW'(1);
    end
  end

  always_comb begin
    vld_d = '0;
    err_d = '0;
    for (int i = 0; i < LATENCY; i++) begin
      dat_d[i] = '0;
    end
    if (CYC_I) begin
      vld_d[0] = accept;
      err_d[0] = accept & req_bad;
      dat_d[0] = (accept && !req_bad && !WE_I) ? mem_q[word_idx] : '0;
      for (int i = 1; i < LATENCY; i++) begin
        vld_d[i] = vld_q[i-1];
        err_d[i] = err_q[i-1];
        dat_d[i] = dat_q[i-1];
      end
    end
  end

  always_comb begin
    ack_d   = CYC_I & vld_q[LAST] & ~err_q[LAST];
    err_o_d = CYC_I & vld_q[LAST] & err_q[LAST];
    dat_o_d = ack_d ? dat_q[LAST] : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_q     <= 1'b0;
      gnt_cnt_q <= '0;
      out_q     <= '0;
      vld_q     <= '0;
      err_q     <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        dat_q[i] <= '0;
      end
      ack_q     <= 1'b0;
      err_o_q   <= 1'b0;
      dat_o_q   <= '0;
    end else begin
      gnt_q     <= gnt_d;
      gnt_cnt_q <= gnt_cnt_d;
      out_q     <= out_d;
      vld_q     <= vld_d;
      err_q     <= err_d;
      for (int i = 0; i < LATENCY; i++) begin
        dat_q[i] <= dat_d[i];
      end
      ack_q     <= ack_d;
      err_o_q   <= err_o_d;
      dat_o_q   <= dat_o_d;
    end
  end

  // Storage keeps its contents across reset and bus aborts.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < SEL_WIDTH; b++) begin
        if (SEL_I[b]) begin
          mem_q[word_idx][b*8 +: 8] <= DAT_I[b*8 +: 8];
        end
      end
    end
  end

endmodule
